// File: rtl/pll_lock_supervisor_if.sv
// PLL-facing and status signals of the lock supervisor.
// The master modport is the supervisor side; the slave modport is the PLL/consumer side.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       clk_ready;
    logic       lock_lost;
    logic [7:0] retry_count;
    logic       fail;

    modport master (
        input  pll_locked,
        output pll_rst,
        output clk_ready,
        output lock_lost,
        output retry_count,
        output fail
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  clk_ready,
        input  lock_lost,
        input  retry_count,
        input  fail
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Holds the PLL in reset, waits for a synchronized and continuously stable lock, then
// raises clk_ready. A lock timeout re-resets the PLL, with a bounded number of retries.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 7,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                          refclk,
    input  logic                          rst,
    pll_lock_supervisor_if.master         bus
);

    localparam int unsigned MaxRstLock = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MaxCycles  = (MaxRstLock > STABLE_CYCLES) ? MaxRstLock : STABLE_CYCLES;
    localparam int unsigned CntW       = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t       RstLast     = cnt_t'(RST_CYCLES - 1);
    localparam cnt_t       TimeoutLast = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t       StableLast  = cnt_t'(STABLE_CYCLES - 1);
    localparam logic [7:0] MaxRetry    = (MAX_RETRIES > 255) ? 8'd255 : 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStabilize,
        StReady,
        StFailed
    } state_e;

    state_e                 state_q, state_d;
    cnt_t                   cnt_q, cnt_d;
    logic [7:0]             retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   clk_ready_q, clk_ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   fail_q, fail_d;
    logic                   locked_s;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        case (state_q)
            StResetPll: begin
                if (cnt_q == RstLast) begin
                    cnt_d   = '0;
                    state_d = StWaitLock;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StWaitLock: begin
                // A lock seen on the timeout cycle still wins.
                if (locked_s) begin
                    cnt_d   = '0;
                    state_d = StStabilize;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d = '0;
                    if (retry_q == MaxRetry) begin
                        state_d = StFailed;
                    end else begin
                        state_d = StResetPll;
                        if (retry_q != 8'hff) begin
                            retry_d = retry_q + 8'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StStabilize: begin
                if (!locked_s) begin
                    cnt_d   = '0;
                    state_d = StWaitLock;
                end else if (cnt_q == StableLast) begin
                    cnt_d   = '0;
                    retry_d = 8'd0;
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StReady: begin
                if (!locked_s) begin
                    lock_lost_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StResetPll;
                end
            end
            StFailed: begin
                state_d = StFailed;
            end
            default: begin
                cnt_d   = '0;
                state_d = StResetPll;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same edge as the state.
        pll_rst_d   = (state_d == StResetPll) || (state_d == StFailed);
        clk_ready_d = (state_d == StReady);
        fail_d      = (state_d == StFailed);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= StResetPll;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync_q      <= sync_d;
            pll_rst_q   <= pll_rst_d;
            clk_ready_q <= clk_ready_d;
            lock_lost_q <= lock_lost_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.clk_ready   = clk_ready_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.retry_count = retry_q;
    assign bus.fail        = fail_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scenarios plus randomized lock patterns, checked every cycle against a
// phase/elapsed-time reference model of the supervisor.
module tb_pll_lock_supervisor;

    localparam int unsigned RstCycles    = 4;
    localparam int unsigned LockTimeout  = 20;
    localparam int unsigned StableCycles = 8;
    localparam int unsigned MaxRetries   = 2;
    localparam int unsigned SyncStages   = 2;

    localparam int PhPulse  = 0;
    localparam int PhWait   = 1;
    localparam int PhSettle = 2;
    localparam int PhReady  = 3;
    localparam int PhFailed = 4;

    logic refclk;
    logic rst;

    pll_lock_supervisor_if bus ();

    pll_lock_supervisor #(
        .RST_CYCLES    (RstCycles),
        .LOCK_TIMEOUT  (LockTimeout),
        .STABLE_CYCLES (StableCycles),
        .MAX_RETRIES   (MaxRetries),
        .SYNC_STAGES   (SyncStages)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current phase, cycles spent in it, retries used, pending lost pulse.
    int m_ph;
    int m_el;
    int m_retries;
    bit m_lost;
    bit m_sync[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph      = PhPulse;
        m_el      = 0;
        m_retries = 0;
        m_lost    = 1'b0;
        m_sync.delete();
        for (int i = 0; i < int'(SyncStages); i++) m_sync.push_back(1'b0);
    endtask

    task automatic model_step(input bit lk);
        bit ls;
        ls = m_sync.pop_front();
        m_sync.push_back(lk);
        m_lost = 1'b0;
        case (m_ph)
            PhPulse: begin
                m_el++;
                if (m_el == int'(RstCycles)) begin
                    m_ph = PhWait;
                    m_el = 0;
                end
            end
            PhWait: begin
                if (ls) begin
                    m_ph = PhSettle;
                    m_el = 0;
                end else begin
                    m_el++;
                    if (m_el == int'(LockTimeout)) begin
                        m_el = 0;
                        if (m_retries == int'(MaxRetries)) m_ph = PhFailed;
                        else begin
                            m_retries++;
                            m_ph = PhPulse;
                        end
                    end
                end
            end
            PhSettle: begin
                if (!ls) begin
                    m_ph = PhWait;
                    m_el = 0;
                end else begin
                    m_el++;
                    if (m_el == int'(StableCycles)) begin
                        m_ph      = PhReady;
                        m_retries = 0;
                    end
                end
            end
            PhReady: begin
                if (!ls) begin
                    m_lost = 1'b1;
                    m_ph   = PhPulse;
                    m_el   = 0;
                end
            end
            default: m_ph = PhFailed;
        endcase
    endtask

    task automatic check_outputs(input string where);
        check_eq({where, " pll_rst"}, 32'(bus.pll_rst),
                 (m_ph == PhPulse || m_ph == PhFailed) ? 32'd1 : 32'd0);
        check_eq({where, " clk_ready"}, 32'(bus.clk_ready), (m_ph == PhReady) ? 32'd1 : 32'd0);
        check_eq({where, " lock_lost"}, 32'(bus.lock_lost), 32'(m_lost));
        check_eq({where, " retry_count"}, 32'(bus.retry_count), 32'(m_retries));
        check_eq({where, " fail"}, 32'(bus.fail), (m_ph == PhFailed) ? 32'd1 : 32'd0);
    endtask

    task automatic cyc(input bit lk);
        bus.pll_locked = lk;
        @(posedge refclk);
        if (rst) model_reset();
        else model_step(lk);
        #1;
        check_outputs("cyc");
    endtask

    // Assert rst between edges, check the immediate effect, then release mid-cycle.
    task automatic pulse_reset();
        #4;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge refclk);
        #1;
        check_outputs("rst_held");
        #5;
        rst = 1'b0;
    endtask

    initial begin
        int fell_at;
        int rise_at;
        int lost_at;
        int hi;
        int falls;
        bit prev;
        bit lk;
        int len;

        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        model_reset();
        repeat (2) @(posedge refclk);
        #1;
        check_outputs("reset");
        #5;
        rst = 1'b0;

        // Clean lock
        fell_at = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b0);
            if (!bus.pll_rst) begin
                fell_at = i;
                break;
            end
        end
        check_eq("pll_rst_width", 32'(fell_at), 32'd4);
        repeat (4) cyc(1'b0);
        rise_at = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1);
            if (bus.clk_ready) begin
                rise_at = i;
                break;
            end
        end
        check_eq("clk_ready_latency", 32'(rise_at), 32'd11);

        // Loss in READY
        repeat (3) cyc(1'b1);
        lost_at = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0);
            if (bus.lock_lost) begin
                lost_at = i;
                break;
            end
        end
        check_eq("lock_lost_latency", 32'(lost_at), 32'd3);
        hi = bus.pll_rst ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0);
            if (!bus.pll_rst) break;
            hi++;
        end
        check_eq("relock_pulse_width", 32'(hi), 32'd4);

        // Never lock, then async reset out of FAILED
        pulse_reset();
        falls = 0;
        prev  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0);
            if (prev && !bus.pll_rst) falls++;
            prev = bus.pll_rst;
        end
        check_eq("pll_rst_pulses", 32'(falls), 32'd3);
        check_eq("failed_sticky", 32'(bus.fail), 32'd1);
        pulse_reset();

        // Lock on retry
        repeat (27) cyc(1'b0);
        rise_at = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc(1'b1);
            if (bus.clk_ready) begin
                rise_at = i;
                break;
            end
        end
        check_eq("retry_lock_ready", 32'(bus.clk_ready), 32'd1);

        // Unstable lock during STABILIZE
        pulse_reset();
        repeat (4) cyc(1'b0);
        repeat (8) cyc(1'b1);
        repeat (4) cyc(1'b0);
        for (int i = 1; i <= 60; i++) begin
            cyc(1'b1);
            if (bus.clk_ready) break;
        end
        check_eq("unstable_then_ready", 32'(bus.clk_ready), 32'd1);

        // Async reset mid-STABILIZE
        pulse_reset();
        repeat (4) cyc(1'b0);
        repeat (6) cyc(1'b1);
        pulse_reset();

        // Randomized lock patterns with occasional resets
        for (int seg = 0; seg < 200; seg++) begin
            lk  = ($urandom_range(0, 9) < 7);
            len = int'($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) pulse_reset();
            for (int k = 0; k < len; k++) cyc(lk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
